// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write arbiter.
//   - frame-buffer geometry (words per row, rows, address field widths)
//   - fb_entry_t: one buffered pixel-word write, frame bit latched at push time
//   - arb_state_t: SRAM port arbiter states
//   - fb_addr(): SRAM word address {2'b00, frame, y, x}
package fb_pkg;

    localparam int unsigned FB_WORDS_PER_ROW = 160;
    localparam int unsigned FB_ROWS          = 480;
    localparam int unsigned FB_ROW_BITS      = 9;
    localparam int unsigned FB_COL_BITS      = 8;
    localparam int unsigned FB_ADDR_BITS     = 20;
    localparam int unsigned FB_DATA_BITS     = 16;

    typedef struct packed {
        logic                    frame;
        logic [FB_ROW_BITS-1:0]  y;
        logic [FB_COL_BITS-1:0]  x;
        logic [FB_DATA_BITS-1:0] data;
    } fb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } arb_state_t;

    function automatic logic [FB_ADDR_BITS-1:0] fb_addr(
        input logic                   frame,
        input logic [FB_ROW_BITS-1:0] y,
        input logic [FB_COL_BITS-1:0] x
    );
        return {2'b00, frame, y, x};
    endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO with registered full flag.
//   clk_i    clock
//   rst_i    synchronous active-high reset, empties the FIFO
//   push_i   write wdata_i (accepted when not full, or when full and popping)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  entry to write
//   rdata_o  current head entry (valid when !empty_o)
//   full_o   registered, reflects the post-update count
//   empty_o  no entries stored
//   count_o  number of stored entries
module fb_sync_fifo #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CntW'(Depth));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer SRAM port arbiter.
// Buffers copy-engine pixel-word writes in a FIFO and shares the single SRAM port
// between VGA scan-out reads (always first) and buffered writes. Owns the
// double-buffer frame select; writes always target the back frame.
//   Clk, Reset                clock, synchronous active-high reset
//   program_write/x/y/data    write strobe, word column, row, four packed pixels
//   vga_rd_req/x/y            scan-out read request (level) and word address
//   vga_rd_data/valid         read word, two cycles after the request
//   vsync_start, swap_req     vertical-blank pulse, front/back swap request
//   current_frame, swap_done  displayed frame, one-cycle pulse when a swap lands
//   fifo_full, overflow       FIFO full status, sticky dropped-write flag
//   sram_*                    SRAM address/data/strobes (strobes active low)
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ROW_BITS   = 9,
    parameter int unsigned COL_BITS   = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        program_write,
    input  logic [9:0]  program_x,
    input  logic [9:0]  program_y,
    input  logic [15:0] program_data,
    input  logic        vga_rd_req,
    input  logic [7:0]  vga_rd_x,
    input  logic [8:0]  vga_rd_y,
    output logic [15:0] vga_rd_data,
    output logic        vga_rd_valid,
    input  logic        vsync_start,
    input  logic        swap_req,
    output logic        current_frame,
    output logic        swap_done,
    output logic        fifo_full,
    output logic        overflow,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_drive,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] MaxX = 10'(FB_WORDS_PER_ROW);
    localparam logic [9:0] MaxY = 10'(FB_ROWS);

    arb_state_t state_q, state_d;

    logic        current_frame_q, current_frame_d;
    logic        swap_pend_q, swap_pend_d;
    logic        swap_done_q, swap_done_d;
    logic        overflow_q, overflow_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        sram_drive_q, sram_drive_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic        sram_oe_n_q, sram_oe_n_d;
    logic        sram_ce_n_q, sram_ce_n_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic            coord_ok;
    logic            wr_req;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full_w;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    fb_entry_t       push_entry;
    fb_entry_t       head_entry;
    logic            swap_pend_any;
    logic            do_swap;

    // ------------------------------------------------------------------
    // Write intake
    // ------------------------------------------------------------------
    // Out-of-range coordinates are silently discarded; they never count as overflow.
    assign coord_ok = (program_x < MaxX) && (program_y < MaxY);
    assign wr_req   = program_write && coord_ok;

    always_comb begin
        push_entry       = '0;
        push_entry.frame = ~current_frame_q;
        push_entry.y     = program_y[ROW_BITS-1:0];
        push_entry.x     = program_x[COL_BITS-1:0];
        push_entry.data  = program_data;
    end

    assign fifo_pop  = (state_d == StWrite);
    assign fifo_push = wr_req && (!fifo_full_w || fifo_pop);

    fb_sync_fifo #(
        .Width ($bits(fb_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign overflow_d = overflow_q | (wr_req & fifo_full_w & ~fifo_pop);

    // ------------------------------------------------------------------
    // Arbiter next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StRead: begin
                // After a read the SRAM may still be driving the bus, so a write
                // waits one idle cycle before we start driving it.
                if (vga_rd_req) begin
                    state_d = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (vga_rd_req) begin
                    state_d = StRead;
                end else if (!fifo_empty) begin
                    state_d = StWrite;
                end
            end
        endcase
    end

    // SRAM strobes and address are registered for the state being entered.
    always_comb begin
        sram_ce_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        sram_drive_d = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_d)
            StRead: begin
                sram_ce_n_d = 1'b0;
                sram_oe_n_d = 1'b0;
                sram_addr_d = fb_addr(current_frame_q, vga_rd_y, vga_rd_x);
            end
            StWrite: begin
                sram_ce_n_d  = 1'b0;
                sram_we_n_d  = 1'b0;
                sram_drive_d = 1'b1;
                sram_addr_d  = fb_addr(head_entry.frame, head_entry.y, head_entry.x);
                sram_wdata_d = head_entry.data;
            end
            default: ;
        endcase
    end

    // Read data is sampled at the end of the READ cycle and shown the cycle after.
    assign rd_valid_d = (state_q == StRead);
    assign rd_data_d  = rd_valid_d ? sram_rdata : rd_data_q;

    // ------------------------------------------------------------------
    // Frame swap
    // ------------------------------------------------------------------
    // A same-cycle swap_req is folded in so it is evaluated on this vsync_start.
    // Swapping waits until every queued write has reached the SRAM.
    assign swap_pend_any   = swap_pend_q | swap_req;
    assign do_swap         = vsync_start && swap_pend_any && (fifo_count == '0)
                             && (state_q != StWrite);
    assign swap_pend_d     = swap_pend_any & ~do_swap;
    assign current_frame_d = current_frame_q ^ do_swap;
    assign swap_done_d     = do_swap;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= StIdle;
            current_frame_q <= 1'b0;
            swap_pend_q     <= 1'b0;
            swap_done_q     <= 1'b0;
            overflow_q      <= 1'b0;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
            sram_drive_q    <= 1'b0;
            sram_we_n_q     <= 1'b1;
            sram_oe_n_q     <= 1'b1;
            sram_ce_n_q     <= 1'b1;
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            current_frame_q <= current_frame_d;
            swap_pend_q     <= swap_pend_d;
            swap_done_q     <= swap_done_d;
            overflow_q      <= overflow_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
            sram_drive_q    <= sram_drive_d;
            sram_we_n_q     <= sram_we_n_d;
            sram_oe_n_q     <= sram_oe_n_d;
            sram_ce_n_q     <= sram_ce_n_d;
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    assign vga_rd_data   = rd_data_q;
    assign vga_rd_valid  = rd_valid_q;
    assign current_frame = current_frame_q;
    assign swap_done     = swap_done_q;
    assign fifo_full     = fifo_full_w;
    assign overflow      = overflow_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;
    assign sram_drive    = sram_drive_q;
    // An in-flight write is cut off in the very cycle Reset is raised.
    assign sram_we_n     = sram_we_n_q | Reset;
    assign sram_oe_n     = sram_oe_n_q;
    assign sram_ce_n     = sram_ce_n_q;

endmodule
